// File: rtl/multdiv_sequencer.sv
// ============================================================================
// Module      : multdiv_sequencer
// Description : Load/step/done sequencer for the iterative multiply/divide
//               datapath; owns no arithmetic, only strobes and a step index.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module multdiv_sequencer #(
    parameter int MULT_STEPS = 16,
    parameter int DIV_STEPS  = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             divisor_zero,
    input  logic             mult_overflow,
    output logic             dp_load,
    output logic             dp_mult_step,
    output logic             dp_div_step,
    output logic             dp_mode,
    output logic [CNT_W-1:0] step_count,
    output logic             busy,
    output logic             data_resultRDY,
    output logic             data_exception
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MULT = 3'd2,
        S_DIV  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_mult_last = CNT_W'(MULT_STEPS - 1);
    localparam logic [CNT_W-1:0] c_div_last  = CNT_W'(DIV_STEPS - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             r_mode;
    logic             r_exc;
    logic             w_start;
    logic             w_dz_hit;

    assign w_start  = ctrl_MULT | ctrl_DIV;
    assign w_dz_hit = (r_state == S_LOAD) && r_mode && divisor_zero;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A start pulse pre-empts every state, including an operation in flight.
    always_comb begin
        w_next = r_state;
        if (w_start) begin
            w_next = S_LOAD;
        end else begin
            case (r_state)
                S_IDLE: w_next = S_IDLE;
                S_LOAD: begin
                    if (w_dz_hit) begin
                        w_next = S_DONE;
                    end else if (r_mode) begin
                        w_next = S_DIV;
                    end else begin
                        w_next = S_MULT;
                    end
                end
                S_MULT: if (r_count == c_mult_last) w_next = S_DONE;
                S_DIV:  if (r_count == c_div_last)  w_next = S_DONE;
                S_DONE: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // The counter stops on the last step so the final index holds through DONE/IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_mode  <= 1'b0;
            r_exc   <= 1'b0;
        end else if (w_start) begin
            r_count <= '0;
            r_mode  <= ctrl_DIV & ~ctrl_MULT;
            r_exc   <= 1'b0;
        end else begin
            if (w_dz_hit) begin
                r_exc <= 1'b1;
            end
            if ((r_state == S_MULT && r_count != c_mult_last) ||
                (r_state == S_DIV  && r_count != c_div_last)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign dp_load        = (r_state == S_LOAD);
    assign dp_mult_step   = (r_state == S_MULT);
    assign dp_div_step    = (r_state == S_DIV);
    assign dp_mode        = r_mode;
    assign step_count     = r_count;
    assign busy           = (r_state == S_LOAD) || (r_state == S_MULT) || (r_state == S_DIV);
    assign data_resultRDY = (r_state == S_DONE);
    assign data_exception = (r_state == S_DONE) && (r_exc || (!r_mode && mult_overflow));

endmodule

`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
// ============================================================================
// Module      : tb_multdiv_sequencer
// Description : Directed scoreboard bench for multdiv_sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_multdiv_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ctrl_MULT = 1'b0;
    logic       ctrl_DIV = 1'b0;
    logic       divisor_zero = 1'b0;
    logic       mult_overflow = 1'b0;
    logic       dp_load;
    logic       dp_mult_step;
    logic       dp_div_step;
    logic       dp_mode;
    logic [5:0] step_count;
    logic       busy;
    logic       data_resultRDY;
    logic       data_exception;

    typedef struct {
        int   due;
        logic exc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    multdiv_sequencer #(
        .MULT_STEPS(16),
        .DIV_STEPS (32),
        .CNT_W     (6)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .divisor_zero  (divisor_zero),
        .mult_overflow (mult_overflow),
        .dp_load       (dp_load),
        .dp_mult_step  (dp_mult_step),
        .dp_div_step   (dp_div_step),
        .dp_mode       (dp_mode),
        .step_count    (step_count),
        .busy          (busy),
        .data_resultRDY(data_resultRDY),
        .data_exception(data_exception)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 32'({dp_load, dp_mult_step, dp_div_step, dp_mode, step_count,
                      busy, data_resultRDY, data_exception}), 32'd0);
    endtask

    // Pops the scoreboard when a completion appears; flags late or extra ones.
    task automatic monitor();
        exp_t e;
        if (data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rdy_unexpected", 32'(data_resultRDY), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rdy_cycle", 32'(cyc), 32'(e.due));
                chk("rdy_exc", 32'(data_exception), 32'(e.exc));
            end
        end else begin
            chk("exc_qualified", 32'(data_exception), 32'd0);
            if (sb.size() > 0 && cyc >= sb[0].due) begin
                void'(sb.pop_front());
                chk("rdy_missing", 32'(data_resultRDY), 32'd1);
            end
        end
    endtask

    // Advance one cycle, drive inputs just after the edge, observe at the falling edge.
    task automatic cyc_in(input logic m, input logic d, input logic dz, input logic ov);
        @(posedge clock);
        #1;
        cyc++;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        divisor_zero  = dz;
        mult_overflow = ov;
        @(negedge clock);
        monitor();
    endtask

    initial begin
        int n;

        // Reset state
        for (int k = 0; k < 3; k++) begin
            cyc_in(1'b0, 1'b0, 1'b0, 1'b0);
            chk_all_zero("reset_outputs");
        end
        reset_n = 1'b1;

        // Plain multiply: full cycle-by-cycle timeline
        for (int k = 0; k < 20; k++) begin
            cyc_in(k == 0, 1'b0, 1'b0, 1'b0);
            if (k == 0) sb.push_back('{cyc + 18, 1'b0});
            chk("m_load", 32'(dp_load), 32'(k == 1));
            chk("m_step", 32'(dp_mult_step), 32'(k >= 2 && k <= 17));
            chk("m_divstep", 32'(dp_div_step), 32'd0);
            chk("m_busy", 32'(busy), 32'(k >= 1 && k <= 17));
            if (k >= 2 && k <= 17) chk("m_count", 32'(step_count), 32'(k - 2));
            if (k == 18) chk("m_count_hold", 32'(step_count), 32'd15);
            if (k >= 1) chk("m_mode", 32'(dp_mode), 32'd0);
        end

        // Divide, no divide-by-zero; overflow flag high at DONE must be ignored
        n = 0;
        for (int k = 0; k < 37; k++) begin
            cyc_in(1'b0, k == 0, 1'b0, k == 34);
            if (k == 0) sb.push_back('{cyc + 34, 1'b0});
            if (dp_div_step === 1'b1) n++;
            if (k >= 1 && k <= 35) chk("d_mode", 32'(dp_mode), 32'd1);
            if (k == 33) chk("d_count_last", 32'(step_count), 32'd31);
            chk("d_multstep", 32'(dp_mult_step), 32'd0);
        end
        chk("d_nsteps", 32'(n), 32'd32);

        // Divide by zero: no iterations, exception at cycle 2
        for (int k = 0; k < 6; k++) begin
            cyc_in(1'b0, k == 0, k == 1, 1'b0);
            if (k == 0) sb.push_back('{cyc + 2, 1'b1});
            if (k == 1) chk("z_load", 32'(dp_load), 32'd1);
            chk("z_nosteps", 32'({dp_mult_step, dp_div_step}), 32'd0);
        end

        // Multiply with overflow at DONE
        for (int k = 0; k < 20; k++) begin
            cyc_in(k == 0, 1'b0, 1'b0, k == 18);
            if (k == 0) sb.push_back('{cyc + 18, 1'b1});
        end

        // Divide start at cycle 10 of a multiply abandons the multiply
        for (int k = 0; k < 47; k++) begin
            cyc_in(k == 0, k == 10, 1'b0, 1'b0);
            if (k == 0) sb.push_back('{cyc + 18, 1'b0});
            if (k == 10) begin
                sb.delete();
                sb.push_back('{cyc + 34, 1'b0});
            end
            if (k == 11) chk("ab_load", 32'(dp_load), 32'd1);
            if (k == 12) chk("ab_mode", 32'(dp_mode), 32'd1);
            if (k == 18) chk("ab_no_rdy18", 32'(data_resultRDY), 32'd0);
        end

        // Simultaneous starts: multiply wins
        for (int k = 0; k < 20; k++) begin
            cyc_in(k == 0, k == 0, 1'b0, 1'b0);
            if (k == 0) sb.push_back('{cyc + 18, 1'b0});
            if (k == 1) chk("both_mode", 32'(dp_mode), 32'd0);
            if (k == 2) chk("both_steps", 32'({dp_mult_step, dp_div_step}), 32'b10);
        end

        // Asynchronous reset in the middle of a divide
        for (int k = 0; k < 11; k++) begin
            cyc_in(1'b0, k == 0, 1'b0, 1'b0);
            if (k == 0) sb.push_back('{cyc + 34, 1'b0});
        end
        chk("ar_busy_before", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        chk_all_zero("ar_immediate");
        for (int k = 0; k < 3; k++) begin
            cyc_in(1'b0, 1'b0, 1'b0, 1'b0);
            chk_all_zero("ar_held");
        end
        reset_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            cyc_in(1'b0, 1'b0, 1'b0, 1'b0);
            chk_all_zero("ar_idle");
        end

        // Back-to-back: restart in the DONE cycle
        for (int k = 0; k < 39; k++) begin
            cyc_in(k == 0 || k == 18, 1'b0, 1'b0, 1'b0);
            if (k == 0) sb.push_back('{cyc + 18, 1'b0});
            if (k == 18) begin
                chk("bb_rdy", 32'(data_resultRDY), 32'd1);
                sb.push_back('{cyc + 18, 1'b0});
            end
            if (k == 19) chk("bb_load", 32'(dp_load), 32'd1);
        end

        for (int k = 0; k < 3; k++) cyc_in(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Control unit for the iterative multiply/divide datapath in the processor.
- Accepts single-cycle start pulses from the pipeline and latches the operation mode.
- Drives the datapath's load, step and mode strobes for a fixed number of iterations, then reports completion and any exception.
- Contains no arithmetic: the datapath owns the operand/product registers and the Booth-group decode; this block only sequences them.

Parameters:
- MULT_STEPS, 16, iterations per multiply (radix-4 Booth, 2 bits per step over 32-bit operands).
- DIV_STEPS, 32, iterations per divide (1 quotient bit per step).
- CNT_W, 6, step counter width; must hold max(MULT_STEPS, DIV_STEPS).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ctrl_MULT  in  1  one-cycle start pulse for a multiply.
- ctrl_DIV  in  1  one-cycle start pulse for a divide.
- divisor_zero  in  1  datapath flag, valid during the LOAD cycle.
- mult_overflow  in  1  datapath flag, valid during the DONE cycle.
- dp_load  out  1  datapath captures operands and clears the accumulator.
- dp_mult_step  out  1  one Booth iteration this cycle.
- dp_div_step  out  1  one shift/subtract iteration this cycle.
- dp_mode  out  1  0 = multiply, 1 = divide; latched operation.
- step_count  out  CNT_W  current iteration index; the datapath uses it to select the Booth group.
- busy  out  1  high in LOAD, MULT, DIV.
- data_resultRDY  out  1  one-cycle completion pulse.
- data_exception  out  1  qualified by data_resultRDY; 0 whenever resultRDY is 0.

Behaviour:
- States: IDLE, LOAD, MULT, DIV, DONE. Encoding is free; state is not visible at the ports.
- Reset (reset_n low, any time, including mid-operation):
  - state = IDLE, step_count = 0, dp_mode = 0.
  - All strobes, busy, data_resultRDY and data_exception = 0.
  - No resultRDY is issued for an aborted operation.
- Start: a start pulse (ctrl_MULT or ctrl_DIV) sampled in any state:
  - Next state = LOAD.
  - dp_mode latched (1 if ctrl_DIV).
  - step_count cleared.
- Simultaneous ctrl_MULT and ctrl_DIV: multiply wins; dp_mode = 0.
- Start while busy: the current operation is abandoned and the new one restarts from LOAD; no resultRDY for the abandoned operation.
- LOAD (1 cycle):
  - dp_load = 1.
  - If dp_mode = 1 and divisor_zero = 1: set the internal exception flag and go to DONE, skipping all iterations.
  - Otherwise go to MULT or DIV according to dp_mode.
- MULT:
  - dp_mult_step = 1 every cycle; step_count increments 0..MULT_STEPS-1.
  - On the cycle with step_count = MULT_STEPS-1, next state = DONE.
- DIV: same as MULT, using dp_div_step and DIV_STEPS.
- DONE (1 cycle):
  - data_resultRDY = 1.
  - data_exception = latched divide-by-zero flag OR (dp_mode = 0 AND mult_overflow).
  - Next state = IDLE, or LOAD if a start pulse is present this cycle; resultRDY still asserts.
- Strobe/output timing:
  - dp_load, dp_mult_step and dp_div_step are mutually exclusive and decoded from registered state (glitch-free, no combinational path from inputs).
  - dp_mode and step_count hold their values through DONE and IDLE until the next start.
  - The exception flag clears on every start.
- Latency, start pulse at cycle 0:
  - LOAD at cycle 1.
  - Steps at cycles 2..MULT_STEPS+1 (multiply) or 2..DIV_STEPS+1 (divide).
  - resultRDY at cycle 18 for a multiply, cycle 34 for a divide.
  - resultRDY at cycle 2 for a divide by zero.

Test Plan:
- Reset, then ctrl_MULT pulse at cycle 0:
  - dp_load at cycle 1.
  - dp_mult_step high cycles 2..17 with step_count 0..15.
  - data_resultRDY = 1 only at cycle 18, data_exception = 0; busy low at cycle 18.
- ctrl_DIV with divisor_zero = 0: dp_div_step high for exactly 32 cycles, resultRDY at cycle 34, dp_mode = 1 throughout.
- ctrl_DIV with divisor_zero = 1 during LOAD: no step strobes; resultRDY and data_exception both 1 at cycle 2.
- Multiply with mult_overflow = 1 at DONE -> data_exception = 1. A divide with mult_overflow = 1 -> data_exception = 0.
- ctrl_DIV at cycle 10 of a multiply:
  - No resultRDY at cycle 18.
  - LOAD at cycle 11, resultRDY at cycle 44, dp_mode = 1.
- Both starts in the same cycle -> multiply sequence.
- reset_n dropped asynchronously mid-DIV:
  - All outputs 0 immediately and stay 0 until the next start.
- Back-to-back: a start in the DONE cycle gives resultRDY = 1 that cycle and LOAD on the next.
